// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO reader: reader state encoding and
// default sizing for the data path and output buffer.
package fifo_reader_pkg;

    localparam int unsigned DATA_SIZE_DEFAULT = 12;
    localparam int unsigned BUF_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        ERR    = 2'b10
    } state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// Bus between the FIFO reader, the FIFO it drains and the downstream consumer.
// The slave view is the reader itself; the master view is its environment.
interface fifo_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT
);

    // FIFO side
    logic                 fifo_read;
    logic                 fifo_empty;
    logic                 fifo_error;
    logic [DATA_SIZE-1:0] fifo_data_out;

    // Downstream side
    logic [DATA_SIZE-1:0] data_out;
    logic                 data_valid;
    logic                 out_ready;

    modport slave (
        input  fifo_empty,
        input  fifo_error,
        input  fifo_data_out,
        input  out_ready,
        output fifo_read,
        output data_out,
        output data_valid
    );

    modport master (
        output fifo_empty,
        output fifo_error,
        output fifo_data_out,
        output out_ready,
        input  fifo_read,
        input  data_out,
        input  data_valid
    );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry in-order buffer between the FIFO read data and the downstream
// port. Head and valid are registers so the output never glitches.
module skid_buffer
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] data,
    output logic [1:0]           count,
    output logic [DATA_SIZE-1:0] head,
    output logic                 valid
);

    logic [DATA_SIZE-1:0] tail_q;
    logic [1:0]           count_d;
    logic                 do_pop;

    assign do_pop = pop && (count != 2'd0);

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_d = count + {1'b0, push} - {1'b0, do_pop};
    end

    // Storage update: head is always the oldest word, tail the younger one.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count  <= '0;
            head   <= '0;
            tail_q <= '0;
            valid  <= 1'b0;
        end else begin
            count <= count_d;
            valid <= (count_d != 2'd0);
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head   <= data;
                    else               tail_q <= data;
                end
                2'b01: begin
                    if (count == 2'd2) head <= tail_q;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head   <= tail_q;
                        tail_q <= data;
                    end else begin
                        head <= data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Drains a registered-output FIFO into a two-entry output buffer, issuing
// reads only when a buffer slot is guaranteed for the returning word.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                enable,
    input  logic                err_clear,
    fifo_reader_if.slave        bus,
    output logic                rd_error,
    output logic [15:0]         words_read
);

    // A read may issue while the slots already claimed stay below the depth.
    localparam logic [2:0] CREDIT_LIMIT = 3'(BUF_DEPTH - 1);

    state_t     state_q;
    state_t     state_d;
    logic       inflight_q;
    logic       pop;
    logic [1:0] buf_count;
    logic [2:0] credit_used;

    assign pop         = bus.data_valid && bus.out_ready;
    assign credit_used = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign bus.fifo_read = (state_q == ACTIVE) && enable && !bus.fifo_empty
                           && (credit_used <= CREDIT_LIMIT);
    assign rd_error    = (state_q == ERR);

    // Next-state selection; a FIFO error overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (bus.fifo_error) begin
            state_d = ERR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable && !bus.fifo_empty) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (!enable || (bus.fifo_empty && !inflight_q && buf_count == 2'd0))
                        state_d = IDLE;
                end
                ERR: begin
                    if (err_clear) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, read-in-flight flag and delivered-word counter.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            words_read <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= bus.fifo_read;
            if (pop) words_read <= words_read + 16'd1;
        end
    end

    // Word returned by last cycle's read is captured here, in any state.
    skid_buffer #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid_buffer (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (inflight_q),
        .pop     (pop),
        .data    (bus.fifo_data_out),
        .count   (buf_count),
        .head    (bus.data_out),
        .valid   (bus.data_valid)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO model feeds the reader and a
// scoreboard predicts every delivered word, its arrival time and the count.
module tb_fifo_reader;

    localparam int unsigned DW     = 12;
    localparam int          FDEPTH = 256;

    logic        clk       = 1'b0;
    logic        reset_L   = 1'b0;
    logic        enable    = 1'b0;
    logic        err_clear = 1'b0;
    logic        rd_error;
    logic [15:0] words_read;

    fifo_reader_if #(.DATA_SIZE(DW)) bus();

    fifo_reader #(
        .DATA_SIZE (DW),
        .BUF_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (enable),
        .err_clear  (err_clear),
        .bus        (bus),
        .rd_error   (rd_error),
        .words_read (words_read)
    );

    always #5 clk = ~clk;

    // FIFO environment: registered read data, empty flag from occupancy.
    logic [DW-1:0] mem [FDEPTH];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc    = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_read) begin
            bus.fifo_data_out <= mem[rd_ptr % FDEPTH];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    // Reference model state
    logic [DW-1:0] exp_q[$];
    int            avail_q[$];
    logic [DW-1:0] pend[$];
    logic [15:0]   exp_wr = '0;
    bit            err_m  = 1'b0;
    bit            obs_read;
    bit            obs_valid;
    int            n_chk  = 0;
    int            n_err  = 0;
    int            exp_rd [10] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, then check and advance the model.
    task automatic step(input bit en, input bit rdy, input bit ferr, input bit eclr, input int npush);
        bit exp_valid;
        @(negedge clk);
        enable         = en;
        bus.out_ready  = rdy;
        bus.fifo_error = ferr;
        err_clear      = eclr;
        for (int i = 0; i < npush; i++) begin
            if (wr_ptr - rd_ptr < 200) begin
                mem[wr_ptr % FDEPTH] = (pend.size() > 0) ? pend.pop_front() : DW'($urandom);
                wr_ptr++;
            end
        end
        #1;
        obs_read  = bus.fifo_read;
        obs_valid = bus.data_valid;
        exp_valid = (exp_q.size() > 0) && (avail_q[0] <= cyc);
        check("data_valid", 32'(bus.data_valid), 32'(exp_valid));
        if (exp_valid) check("data_out", 32'(bus.data_out), 32'(exp_q[0]));
        check("words_read", 32'(words_read), 32'(exp_wr));
        check("rd_error", 32'(rd_error), 32'(err_m));
        if (!en || err_m || bus.fifo_empty) check("read_gated", 32'(bus.fifo_read), 32'(0));
        if (exp_valid && rdy) begin
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
            exp_wr++;
        end
        if (bus.fifo_read) begin
            exp_q.push_back(mem[rd_ptr % FDEPTH]);
            avail_q.push_back(cyc + 2);
        end
        check("outstanding_le_2", 32'(exp_q.size() <= 2), 32'(1));
        if (ferr)      err_m = 1'b0 | 1'b1;
        else if (eclr) err_m = 1'b0;
    endtask

    // Asynchronous reset mid-cycle, then release with words waiting and enable high.
    task automatic reset_pulse();
        @(negedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        check("rst_mid_data_valid", 32'(bus.data_valid), 32'(0));
        check("rst_mid_data_out", 32'(bus.data_out), 32'(0));
        check("rst_mid_words_read", 32'(words_read), 32'(0));
        check("rst_mid_rd_error", 32'(rd_error), 32'(0));
        check("rst_mid_fifo_read", 32'(bus.fifo_read), 32'(0));
        exp_q.delete();
        avail_q.delete();
        exp_wr = '0;
        err_m  = 1'b0;
        wr_ptr = rd_ptr;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mem[wr_ptr % FDEPTH] = DW'($urandom);
            wr_ptr++;
        end
        enable        = 1'b1;
        bus.out_ready = 1'b1;
        reset_L       = 1'b1;
        #1;
        check("first_read_gap", 32'(bus.fifo_read), 32'(0));
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.out_ready  = 1'b0;
        bus.fifo_error = 1'b0;
        #1;
        check("rst_data_valid", 32'(bus.data_valid), 32'(0));
        check("rst_data_out", 32'(bus.data_out), 32'(0));
        check("rst_words_read", 32'(words_read), 32'(0));
        check("rst_rd_error", 32'(rd_error), 32'(0));
        check("rst_fifo_read", 32'(bus.fifo_read), 32'(0));
        repeat (2) @(negedge clk);
        reset_L = 1'b1;

        // Three-word burst at full throughput, then a late word seen from IDLE.
        pend.push_back(12'h0A1);
        pend.push_back(12'h0A2);
        pend.push_back(12'h0A3);
        for (int s = 0; s < 10; s++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, (s == 0) ? 3 : ((s == 8) ? 1 : 0));
            check($sformatf("burst_read[%0d]", s), 32'(obs_read), 32'(exp_rd[s]));
            check($sformatf("burst_valid[%0d]", s), 32'(obs_valid), 32'(s >= 3 && s <= 5));
            if (s == 7) check("burst_count", 32'(words_read), 32'(3));
        end
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Drop enable right after a read has been issued.
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 2);
        guard = 0;
        while (!obs_read && guard < 10) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1);
            guard++;
        end
        check("en_drop_read_seen", 32'(obs_read), 32'(1));
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Downstream stall for four cycles while streaming.
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 2);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1);
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 1);

        // Single-cycle FIFO error with a full buffer, drain in ERR, then clear.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("err_flag", 32'(rd_error), 32'(1));
        check("err_no_read", 32'(obs_read), 32'(0));
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1);
        check("err_cleared", 32'(rd_error), 32'(0));
        repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0, 1);

        // Randomized traffic.
        repeat (800) begin
            bit en;
            bit rdy;
            bit ferr;
            bit eclr;
            en   = ($urandom_range(0, 9) != 0);
            rdy  = ($urandom_range(0, 9) < 7);
            ferr = ($urandom_range(0, 79) == 0);
            eclr = err_m && ($urandom_range(0, 3) == 0);
            step(en, rdy, ferr, eclr, int'($urandom_range(0, 2)));
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 0);

        // Reset with two words buffered.
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 3);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("pre_reset_valid", 32'(obs_valid), 32'(1));
        reset_pulse();

        // Stream up to the counter wrap point.
        guard = 0;
        while (exp_wr != 16'hFFFE && guard < 70000) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1);
            guard++;
        end
        check("wrap_budget", 32'(guard < 70000), 32'(1));
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1);
        check("wrap_pre", 32'(words_read), 32'(16'hFFFE));
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("wrap_ffff", 32'(words_read), 32'(16'hFFFF));
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("wrap_0000", 32'(words_read), 32'(0));
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_SIZE, default 12, width of every data word; SHALL match the attached FIFO.
REQ-002 Parameter BUF_DEPTH, default 2, output buffer entries; SHALL be fixed at 2 (other values unsupported).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = reader may issue FIFO reads.
REQ-006 err_clear  input  1  single-cycle pulse that leaves ERR state.
REQ-007 fifo_empty  input  1  FIFO empty flag, combinational from FIFO count.
REQ-008 fifo_error  input  1  FIFO error flag.
REQ-009 fifo_data_out  input  DATA_SIZE  FIFO read data, registered, valid one cycle after the read.
REQ-010 out_ready  input  1  downstream accepts the word this cycle.
REQ-011 fifo_read  output  1  read strobe to FIFO.
REQ-012 data_out  output  DATA_SIZE  head word of the output buffer.
REQ-013 data_valid  output  1  data_out holds a valid word.
REQ-014 rd_error  output  1  1 while in ERR state.
REQ-015 words_read  output  16  count of words delivered downstream.

Function
REQ-016 States SHALL be IDLE, ACTIVE, ERR; encoding 2 bits.
REQ-017 IDLE->ACTIVE SHALL occur when enable=1 and fifo_empty=0.
REQ-018 ACTIVE->IDLE SHALL occur when enable=0, or when fifo_empty=1 with inflight=0 and buffer empty.
REQ-019 Any state->ERR SHALL occur on any edge sampling fifo_error=1; ERR has priority over every other transition.
REQ-020 ERR->IDLE SHALL occur only when err_clear=1 and fifo_error=0.
REQ-021 fifo_read SHALL be combinational: state==ACTIVE && enable && !fifo_empty && (buf_count + inflight - pop) <= 1, where pop = data_valid && out_ready.
REQ-022 inflight SHALL be a register equal to fifo_read of the previous cycle.
REQ-023 When inflight=1, fifo_data_out SHALL be written into the buffer tail at that edge; read-to-data_valid latency is 2 cycles (data appears at FIFO output 1 cycle after the read and is captured at the following edge).
REQ-024 A simultaneous push and pop SHALL both occur, with buf_count unchanged and order preserved.
REQ-025 buf_count + inflight SHALL never exceed 2; overflow is impossible by REQ-021.
REQ-026 With out_ready held at 1 and the FIFO non-empty, fifo_read SHALL assert every cycle (full throughput).
REQ-027 data_out and data_valid SHALL come from registers only; data_out SHALL hold its value while data_valid=1 and out_ready=0.
REQ-028 In ERR or IDLE, fifo_read SHALL be 0; any in-flight word SHALL still be captured and buffered words SHALL still drain to downstream.
REQ-029 words_read SHALL increment on each pop and wrap from 16'hFFFF to 0.
REQ-030 Deasserting enable mid-stream SHALL stop new reads the same cycle without losing the in-flight word.

Reset
REQ-031 While reset_L=0, asynchronously: state=IDLE, inflight=0, buf_count=0, data_out=0, data_valid=0, rd_error=0, words_read=0; fifo_read=0.
REQ-032 Reset asserted mid-transfer SHALL discard in-flight and buffered words.
REQ-033 The first read SHALL occur no earlier than the second rising edge after reset_L rises.

Structure
REQ-034 A shared package SHALL hold the state encoding constants and the DATA_SIZE default.
REQ-035 The 2-entry buffer SHALL be a sub-module named skid_buffer (push, pop, data, count, head output).
REQ-036 The FSM, read-credit logic and words_read counter SHALL reside in fifo_reader.

Verification
REQ-037 FIFO holds 3 words 0x0A1, 0x0A2, 0x0A3, enable=1, out_ready=1 -> fifo_read high 3 consecutive cycles; data_valid for 3 cycles starting 2 cycles after the first read; words_read=3; state returns to IDLE.
REQ-038 Streaming with out_ready=0 for 4 cycles -> at most 2 reads outstanding, data_out stable, and no word lost or duplicated after out_ready returns to 1.
REQ-039 fifo_error forced to 1 for 1 cycle -> rd_error=1 next cycle, fifo_read=0 while rd_error=1, buffered words still delivered; err_clear pulse -> IDLE.
REQ-040 words_read preloaded to 0xFFFE by 2 transfers before 0xFFFF... (set up via 65534 transfers or force) -> two more pops give 0xFFFF then 0x0000.
REQ-041 reset_L pulled low with 2 words buffered -> data_valid=0 and buf_count=0 immediately, without waiting for clk.
REQ-042 enable deasserted on the same cycle a read is issued -> that word still appears on data_out and no further fifo_read occurs.
